// File: rtl/sram_pro_pkg.sv
// Shared definitions for the pro-channel SRAM initiator: FSM encoding,
// default geometry/timing and the inactive level of the active-low strobes.
package sram_pro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int unsigned DEF_ADDR_W   = 20;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_WAIT_CYC = 2;

  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_pro_access_ctrl.sv
// Single-beat request/ready to timed SRAM strobe initiator for the 32-bit pro
// channel. Define SRAM_PRO_BACK2BACK_EN to also accept requests in RECOVER.
module sram_pro_access_ctrl
  import sram_pro_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic [ADDR_W-1:0] addr_pro,
  output logic              ce_pro,
  output logic              oe_pro,
  output logic              we_pro,
  output logic [DATA_W-1:0] dataout_pro,
  input  logic [DATA_W-1:0] data_pro
);

  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("sram_pro_access_ctrl: WAIT_CYC must be in 1..15");
  end

  localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       op_we;
  logic       we_nxt;
  logic       accept;
  logic       ready_nxt;

  assign accept = req && req_ready;
  assign we_nxt = accept ? req_we : op_we;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == '0) state_nxt = RECOVER;
      RECOVER: begin
        state_nxt = IDLE;
`ifdef SRAM_PRO_BACK2BACK_EN
        if (accept) state_nxt = SETUP;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_nxt = (state_nxt == IDLE);
`ifdef SRAM_PRO_BACK2BACK_EN
    ready_nxt = ready_nxt || (state_nxt == RECOVER);
`endif
  end

  // Every output is registered from the next state, so the bus shows the
  // phase's strobes during the cycle that phase actually occupies.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      op_we       <= 1'b0;
      addr_pro    <= '0;
      dataout_pro <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      wr_done     <= 1'b0;
      req_ready   <= 1'b1;
      ce_pro      <= STROBE_OFF;
      oe_pro      <= STROBE_OFF;
      we_pro      <= STROBE_OFF;
    end else begin
      if (accept) begin
        op_we       <= req_we;
        addr_pro    <= req_addr;
        dataout_pro <= req_we ? req_wdata : '0;
      end else if (state_nxt == IDLE) begin
        dataout_pro <= '0;
      end

      if (state == SETUP)
        wait_cnt <= WAIT_CNT_INIT;
      else if (state == ACCESS && wait_cnt != '0)
        wait_cnt <= wait_cnt - 4'd1;

      if (state == ACCESS && wait_cnt == '0 && !op_we)
        rd_data <= data_pro;

      ce_pro    <= (state_nxt == IDLE) ? STROBE_OFF : ~STROBE_OFF;
      oe_pro    <= ~(!we_nxt && (state_nxt == SETUP || state_nxt == ACCESS));
      we_pro    <= ~(we_nxt && (state_nxt == ACCESS));
      rd_valid  <= (state_nxt == RECOVER) && !op_we;
      wr_done   <= (state_nxt == RECOVER) && op_we;
      req_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_sram_pro_access_ctrl.sv
// Scoreboard bench for sram_pro_access_ctrl: directed accesses against a bus
// memory model, plus WAIT_CYC=1/15 latency instances.
module tb_sram_pro_access_ctrl;

  localparam int W = 2;
`ifdef SRAM_PRO_BACK2BACK_EN
  localparam int PERIOD = W + 2;
`else
  localparam int PERIOD = W + 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_we;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rd_valid, wr_done;
  logic [31:0] rd_data;
  logic [19:0] addr_pro;
  logic        ce_pro, oe_pro, we_pro;
  logic [31:0] dataout_pro, data_pro;

  logic        lx_req;
  logic        ready1, rv1, wd1, ce1, oe1, we1;
  logic [31:0] rdd1, dout1;
  logic [19:0] addr1;
  logic        ready15, rv15, wd15, ce15, oe15, we15;
  logic [31:0] rdd15, dout15;
  logic [19:0] addr15;
  logic [31:0] lx_data1  = 32'h1111_0001;
  logic [31:0] lx_data15 = 32'h1515_000F;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          at_cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] bus_mem [0:4095];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_pro = (!ce_pro && !oe_pro) ? bus_mem[addr_pro[11:0]] : 32'h0;
  always @(posedge clk) if (!ce_pro && !we_pro) bus_mem[addr_pro[11:0]] <= dataout_pro;

  sram_pro_access_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_done(wr_done), .addr_pro(addr_pro), .ce_pro(ce_pro),
    .oe_pro(oe_pro), .we_pro(we_pro), .dataout_pro(dataout_pro), .data_pro(data_pro)
  );

  sram_pro_access_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(1)) u_w1 (
    .clk(clk), .rst(rst), .req(lx_req), .req_we(1'b0), .req_addr(20'h00007),
    .req_wdata(32'h0), .req_ready(ready1), .rd_valid(rv1), .rd_data(rdd1),
    .wr_done(wd1), .addr_pro(addr1), .ce_pro(ce1), .oe_pro(oe1), .we_pro(we1),
    .dataout_pro(dout1), .data_pro(lx_data1)
  );

  sram_pro_access_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(15)) u_w15 (
    .clk(clk), .rst(rst), .req(lx_req), .req_we(1'b0), .req_addr(20'h0000F),
    .req_wdata(32'h0), .req_ready(ready15), .rd_valid(rv15), .rd_data(rdd15),
    .wr_done(wd15), .addr_pro(addr15), .ce_pro(ce15), .oe_pro(oe15), .we_pro(we15),
    .dataout_pro(dout15), .data_pro(lx_data15)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pops one expectation per completion pulse and checks kind, timing, data.
  always @(negedge clk) begin
    if (!rst) begin
      chk("oe_we_both_low", {31'b0, !oe_pro && !we_pro}, 32'h0);
      chk("we_low_without_ce", {31'b0, !we_pro && ce_pro}, 32'h0);
      if (rd_valid || wr_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", {30'b0, rd_valid, wr_done}, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("completion_kind", {30'b0, rd_valid, wr_done}, e.is_rd ? 32'h2 : 32'h1);
          chk("completion_cycle", cyc, e.at_cyc);
          if (e.is_rd) chk("rd_data", rd_data, e.data);
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({nm, "_ready_timeout"}, 32'h0, 32'h1);
  endtask

  // Issues one access from IDLE, walks its strobe sequence and queues the
  // expected completion; for reads d is the expected rd_data.
  task automatic do_access(input bit we, input logic [19:0] a, input logic [31:0] d);
    int acc;
    req = 1'b1; req_we = we; req_addr = a; req_wdata = we ? d : 32'h5A5A_5A5A;
    wait_ready("access");
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req = 1'b0; req_we = ~we; req_addr = 20'hFFFFF; req_wdata = 32'h0BAD_0BAD;
    sb_q.push_back('{is_rd: !we, data: d, at_cyc: acc + W + 1});
    chk("setup_ce", {31'b0, ce_pro}, 32'h0);
    chk("setup_addr", {12'b0, addr_pro}, {12'b0, a});
    chk("setup_we", {31'b0, we_pro}, 32'h1);
    chk("setup_oe", {31'b0, oe_pro}, we ? 32'h1 : 32'h0);
    if (we) chk("setup_dout", dataout_pro, d);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("access_ce", {31'b0, ce_pro}, 32'h0);
      chk("access_addr", {12'b0, addr_pro}, {12'b0, a});
      chk("access_we", {31'b0, we_pro}, we ? 32'h0 : 32'h1);
      chk("access_oe", {31'b0, oe_pro}, we ? 32'h1 : 32'h0);
      if (we) chk("access_dout", dataout_pro, d);
    end
    @(negedge clk);
    chk("recover_strobes", {29'b0, ce_pro, oe_pro, we_pro}, 32'h3);
    chk("recover_addr", {12'b0, addr_pro}, {12'b0, a});
    if (we) chk("recover_dout", dataout_pro, d);
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'h1);
    chk("idle_strobes", {29'b0, ce_pro, oe_pro, we_pro}, 32'h7);
    chk("idle_dout", dataout_pro, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [3];
    int a1, a2, t1, t15, n;
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; lx_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {29'b0, ce_pro, oe_pro, we_pro}, 32'h7);
    chk("rst_addr", {12'b0, addr_pro}, 32'h0);
    chk("rst_dout", dataout_pro, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_pulses", {30'b0, rd_valid, wr_done}, 32'h0);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    do_access(1'b1, 20'h12345, 32'hDEAD_BEEF);
    chk("bus_mem_write", bus_mem[12'h345], 32'hDEAD_BEEF);
    do_access(1'b0, 20'h12345, 32'hDEAD_BEEF);

    // req held high over three writes
    req = 1'b1; req_we = 1'b1; req_addr = 20'h0; req_wdata = 32'h0000_0100;
    for (int j = 0; j < 3; j++) begin
      wait_ready("held");
      @(posedge clk);
      @(negedge clk);
      acc[j] = cyc;
      chk("held_addr", {12'b0, addr_pro}, j);
      chk("held_dout", dataout_pro, 32'h0000_0100 + j);
      sb_q.push_back('{is_rd: 1'b0, data: 32'h0, at_cyc: acc[j] + W + 1});
      req_addr = 20'(j + 1); req_wdata = 32'h0000_0101 + j;
      if (j == 2) req = 1'b0;
    end
    chk("held_period_01", acc[1] - acc[0], PERIOD);
    chk("held_period_12", acc[2] - acc[1], PERIOD);
    repeat (W + 3) @(negedge clk);
    do_access(1'b0, 20'h00001, 32'h0000_0101);
    do_access(1'b0, 20'h00002, 32'h0000_0102);

    // reset during the second ACCESS cycle of a read
    req = 1'b1; req_we = 1'b0; req_addr = 20'h12345;
    wait_ready("abort");
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {29'b0, ce_pro, oe_pro, we_pro}, 32'h7);
    chk("abort_rd_data", rd_data, 32'h0);
    chk("abort_pulses", {30'b0, rd_valid, wr_done}, 32'h0);
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // latency at WAIT_CYC=1 and 15 (accept edge counted as edge 1)
    chk("lx_ready", {30'b0, ready1, ready15}, 32'h3);
    lx_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a1 = cyc;
    lx_req = 1'b0;
    t1 = -1; t15 = -1; n = 0;
    while ((t1 < 0 || t15 < 0) && n < 40) begin
      if (rv1 && t1 < 0) begin t1 = cyc; chk("w1_rd_data", rdd1, 32'h1111_0001); end
      if (rv15 && t15 < 0) begin t15 = cyc; chk("w15_rd_data", rdd15, 32'h1515_000F); end
      if (t1 < 0 || t15 < 0) @(negedge clk);
      n++;
    end
    chk("w1_latency", t1 - a1 + 1, 32'd3);
    chk("w15_latency", t15 - a1 + 1, 32'd17);

`ifdef SRAM_PRO_BACK2BACK_EN
    // read then write back-to-back: second accept in RECOVER, ce held low
    req = 1'b1; req_we = 1'b0; req_addr = 20'h12345; req_wdata = 32'h0;
    wait_ready("b2b_first");
    @(posedge clk);
    @(negedge clk);
    a1 = cyc;
    sb_q.push_back('{is_rd: 1'b1, data: 32'hDEAD_BEEF, at_cyc: a1 + W + 1});
    req_we = 1'b1; req_addr = 20'h00ABC; req_wdata = 32'hCAFE_F00D;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      chk("b2b_ce_low", {31'b0, ce_pro}, 32'h0);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    a2 = cyc;
    req = 1'b0;
    sb_q.push_back('{is_rd: 1'b0, data: 32'h0, at_cyc: a2 + W + 1});
    chk("b2b_period", a2 - a1, W + 2);
    chk("b2b_ce_setup", {31'b0, ce_pro}, 32'h0);
    chk("b2b_addr", {12'b0, addr_pro}, 32'h0000_0ABC);
    chk("b2b_dout", dataout_pro, 32'hCAFE_F00D);
    repeat (W + 1) begin
      @(negedge clk);
      chk("b2b_ce_low2", {31'b0, ce_pro}, 32'h0);
    end
    @(negedge clk);
    do_access(1'b0, 20'h00ABC, 32'hCAFE_F00D);
`endif

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
